bcd_digit_accumulator: RTL

- Sequential stage directly downstream of the 4-bit ">= 10" detector.
- Accepts one decimal digit per handshake and adds it to a multi-digit packed-BCD running total.
- Rippling carry is processed one digit per clock.
- Each digit sum uses the ">= 10" test to select decimal correction (+6, carry out).
- Feeds the display/readout stage with a registered BCD total plus done/overflow/error status.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_digit_accumulator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the digit accumulator and its digit adder.
package bcd_pkg;

  localparam int              BCD_DIGIT_W = 4;
  localparam logic [3:0]      BCD_MAX     = 4'd9;
  localparam logic [3:0]      BCD_CORR    = 4'd6;

  typedef enum logic [1:0] {IDLE, ADD, DONE} acc_state_t;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  function automatic logic is_legal_digit(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder: a + b + cin with >= 10 detection and +6 correction.
// Zero latency; no handshake.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [BCD_DIGIT_W:0] s;
  logic                 ge10;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
    ge10 = (s > {1'b0, BCD_MAX});
    // Adding 6 modulo 16 skips the six unused codes and leaves the decimal remainder.
    sum  = ge10 ? (s[BCD_DIGIT_W-1:0] + BCD_CORR) : s[BCD_DIGIT_W-1:0];
    cout = ge10;
  end

endmodule

// File: rtl/bcd_digit_accumulator.sv
// Packed-BCD running total, one digit accepted per handshake in IDLE, carry rippled one digit per clock;
// done 2..DIGITS+1 cycles after accept. Optional BCD_ACC_SATURATE_EN pins the total at all nines on overflow.
module bcd_digit_accumulator
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DW     = BCD_DIGIT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic [DW*DIGITS-1:0] bcd_total,
  output logic                 done,
  output logic                 overflow,
  output logic                 err
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  acc_state_t             state_q, state_d;
  logic [DW*DIGITS-1:0]   total_q, total_d;
  bcd_digit_t             addend_q, addend_d;
  logic                   carry_q, carry_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   overflow_q, overflow_d;

  bcd_digit_t             add_a, add_b, add_sum;
  logic                   add_cout;

  // The single adder is steered to the digit currently being updated.
  always_comb begin
    add_a = total_q[idx_q*DW +: DW];
    add_b = (idx_q == '0) ? addend_q : '0;
  end

  bcd_digit_add u_digit_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    addend_d   = addend_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    overflow_d = overflow_q;

    if (clear) begin
      state_d    = IDLE;
      total_d    = '0;
      addend_d   = '0;
      carry_d    = 1'b0;
      idx_d      = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_legal_digit(in_data)) begin
              addend_d = in_data;
              carry_d  = 1'b0;
              idx_d    = '0;
              state_d  = ADD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ADD: begin
          total_d[idx_q*DW +: DW] = add_sum;
          carry_d                 = add_cout;
          if (!add_cout || idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (add_cout) begin
              overflow_d = 1'b1;
`ifdef BCD_ACC_SATURATE_EN
              total_d    = {DIGITS{BCD_MAX}};
`endif
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      total_q    <= '0;
      addend_q   <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      addend_q   <= addend_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd_total = total_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule
